// File: rtl/io_stall_ctrl_if.sv
// Handshake bundle between the IO stall controller and the CPU/front-panel side.
interface io_stall_ctrl_if;
    logic        in_inst;
    logic        out_inst;
    logic        btn;
    logic        pc_en;
    logic        in_wait;
    logic        out_wait;
    logic        in_capture;
    logic        out_latch;
    logic [31:0] stall_count;

    modport master (
        output in_inst, out_inst, btn,
        input  pc_en, in_wait, out_wait, in_capture, out_latch, stall_count
    );

    modport slave (
        input  in_inst, out_inst, btn,
        output pc_en, in_wait, out_wait, in_capture, out_latch, stall_count
    );
endinterface

// File: rtl/io_stall_ctrl.sv
// Stalls the PC on IO instructions until a debounced button press confirms them,
// then commits exactly one capture/latch pulse per press.
module io_stall_ctrl #(
    parameter int unsigned DB_CYCLES = 6,
    parameter int unsigned CW        = 3
) (
    input  logic       CLK,
    input  logic       reset,
    io_stall_ctrl_if.slave bus
);
    localparam int unsigned SCW = 32;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [SCW-1:0] SAT_MAX  = '1;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        WAIT     = 3'd1,
        DEBOUNCE = 3'd2,
        COMMIT   = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t         state;
    logic           kind_in;
    logic [CW-1:0]  cnt;
    logic           sync1;
    logic           btn_s;
    logic [SCW-1:0] stall_q;

    logic pc_en_w;
    logic waiting;
    logic io_req;

    // Decoded outputs depend only on state, kind and the instruction flags.
    assign io_req  = bus.in_inst | bus.out_inst;
    assign waiting = (state == WAIT) || (state == DEBOUNCE);
    assign pc_en_w = (state == RUN) ? !io_req : (state == COMMIT);

    assign bus.pc_en       = pc_en_w;
    assign bus.in_wait     = waiting && kind_in;
    assign bus.out_wait    = waiting && !kind_in;
    assign bus.in_capture  = (state == COMMIT) && kind_in;
    assign bus.out_latch   = (state == COMMIT) && !kind_in;
    assign bus.stall_count = stall_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            kind_in <= 1'b1;
            cnt     <= '0;
            sync1   <= 1'b0;
            btn_s   <= 1'b0;
            stall_q <= '0;
        end else begin
            sync1 <= bus.btn;
            btn_s <= sync1;

            if (!pc_en_w && (stall_q != SAT_MAX)) begin
                stall_q <= stall_q + 32'd1;
            end

            case (state)
                RUN: begin
                    if (io_req) begin
                        kind_in <= bus.in_inst;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (btn_s) begin
                        cnt   <= CW'(1);
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else if (cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    cnt   <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A held button must be let go before the next IO instruction can commit.
                    if (!btn_s) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_stall_ctrl.sv
// Self-checking bench for io_stall_ctrl: directed scenarios plus random stimulus
// against a press-counting reference model.
module tb_io_stall_ctrl;
    localparam int DB = 6;

    logic CLK;
    logic reset;
    int   total;
    int   bad;

    io_stall_ctrl_if bus ();

    io_stall_ctrl #(.DB_CYCLES(DB), .CW(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: pending IO kind (0 none, 1 in, 2 out), run of consecutive
    // synchronized-high samples, a one-cycle commit, and a wait-for-release phase.
    int          m_wait;
    int          m_commit;
    int          m_run;
    bit          m_release;
    logic        m_b1, m_b2;
    logic [31:0] m_stall;

    task automatic model_reset();
        m_wait = 0; m_commit = 0; m_run = 0; m_release = 0;
        m_b1 = 1'b0; m_b2 = 1'b0; m_stall = 32'd0;
    endtask

    function automatic logic [36:0] exp_vec();
        logic pe, iw, ow, ic, ol;
        pe = 1'b0; iw = 1'b0; ow = 1'b0; ic = 1'b0; ol = 1'b0;
        if (m_commit != 0) begin
            pe = 1'b1; ic = (m_commit == 1); ol = (m_commit == 2);
        end else if (m_release) begin
            pe = 1'b0;
        end else if (m_wait != 0) begin
            iw = (m_wait == 1); ow = (m_wait == 2);
        end else begin
            pe = !(bus.in_inst | bus.out_inst);
        end
        return {pe, iw, ow, ic, ol, m_stall};
    endfunction

    function automatic logic [36:0] act_vec();
        return {bus.pc_en, bus.in_wait, bus.out_wait, bus.in_capture, bus.out_latch, bus.stall_count};
    endfunction

    task automatic model_edge();
        logic [36:0] e;
        logic bs;
        if (reset) begin
            model_reset();
            return;
        end
        e  = exp_vec();
        bs = m_b2;
        if (!e[36] && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 32'd1;
        if (m_commit != 0) begin
            m_commit = 0; m_release = 1;
        end else if (m_release) begin
            if (!bs) m_release = 0;
        end else if (m_wait != 0) begin
            m_run = bs ? m_run + 1 : 0;
            if (m_run == DB) begin
                m_commit = m_wait; m_wait = 0; m_run = 0;
            end
        end else if (bus.in_inst || bus.out_inst) begin
            m_wait = bus.in_inst ? 1 : 2;
            m_run  = 0;
        end
        m_b2 = m_b1;
        m_b1 = bus.btn;
    endtask

    // Advance one clock, then apply the inputs for the new cycle.
    task automatic cyc(input logic i, input logic o, input logic b);
        @(posedge CLK);
        model_edge();
        #1;
        bus.in_inst = i; bus.out_inst = o; bus.btn = b;
        #1;
    endtask

    task automatic do_reset();
        bus.in_inst = 1'b0; bus.out_inst = 1'b0; bus.btn = 1'b0;
        reset = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (act_vec() !== {5'b10000, 32'd0}) begin
            bad++; $display("FAIL reset_state act=%h exp=%h", act_vec(), {5'b10000, 32'd0});
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (act_vec() !== {5'b10000, 32'd0}) begin
                bad++; $display("FAIL idle cyc=%0d act=%h exp=%h", i, act_vec(), {5'b10000, 32'd0});
            end
        end
    endtask

    task automatic test_input_commit();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(i < 2, 1'b0, (i >= 2) && (i < 12));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL in_commit cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (i == 1) begin
                total++;
                if (bus.in_wait !== 1'b1) begin
                    bad++; $display("FAIL in_wait_start act=%b exp=1", bus.in_wait);
                end
            end
            if (i == 10) begin
                total++;
                if ({bus.in_capture, bus.pc_en} !== 2'b11) begin
                    bad++; $display("FAIL in_commit_cycle10 act=%b exp=11", {bus.in_capture, bus.pc_en});
                end
            end
            if (bus.in_capture === 1'b1) pulses++;
            total++;
            if (bus.out_latch !== 1'b0) begin
                bad++; $display("FAIL in_commit_no_latch cyc=%0d act=%b exp=0", i, bus.out_latch);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL in_commit_pulses act=%0d exp=1", pulses);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        logic b;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            b = ((i >= 2) && (i <= 4)) || (i >= 6);
            cyc(i < 2, i < 2 ? 1'b1 : 1'b0, b);
            bus.in_inst = 1'b0; bus.out_inst = (i < 2); #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL bounce cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (bus.out_latch === 1'b1) begin
                pulses++;
                total++;
                if (i != 14) begin
                    bad++; $display("FAIL bounce_commit_cycle act=%0d exp=14", i);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL bounce_pulses act=%0d exp=1", pulses);
        end
    endtask

    task automatic test_held();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 53; i++) begin
            cyc(1'b0, i < 45, ((i >= 2) && (i <= 30)) || ((i >= 36) && (i < 46)));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL held cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (i >= 11 && i <= 43) begin
                total++;
                if (bus.pc_en !== 1'b0) begin
                    bad++; $display("FAIL held_stall cyc=%0d act=%b exp=0", i, bus.pc_en);
                end
            end
            if (bus.out_latch === 1'b1) begin
                pulses++;
                total++;
                if (i != 10 && i != 44) begin
                    bad++; $display("FAIL held_pulse_cycle act=%0d exp=10_or_44", i);
                end
            end
        end
        total++;
        if (pulses != 2) begin
            bad++; $display("FAIL held_pulses act=%0d exp=2", pulses);
        end
    endtask

    task automatic test_priority_reset();
        do_reset();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if ({bus.in_wait, bus.out_wait} !== 2'b10) begin
            bad++; $display("FAIL priority act=%b exp=10", {bus.in_wait, bus.out_wait});
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL priority_debounce act=%h exp=%h", act_vec(), exp_vec());
        end
        #2;
        reset = 1'b1;
        model_reset();
        bus.btn = 1'b0;
        #1;
        total++;
        if (act_vec() !== {5'b10000, 32'd0}) begin
            bad++; $display("FAIL async_reset act=%h exp=%h", act_vec(), {5'b10000, 32'd0});
        end
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (act_vec() !== {5'b10000, 32'd0}) begin
                bad++; $display("FAIL post_reset cyc=%0d act=%h exp=%h", i, act_vec(), {5'b10000, 32'd0});
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        force dut.stall_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_q;
        m_stall = 32'hFFFFFFFE;
        #1;
        total++;
        if (bus.stall_count !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL sat_preload act=%h exp=fffffffe", bus.stall_count);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (bus.stall_count !== 32'hFFFFFFFF) begin
                bad++; $display("FAIL sat_hold cyc=%0d act=%h exp=ffffffff", i, bus.stall_count);
            end
        end
    endtask

    task automatic test_random();
        int   hold;
        logic b, ii, oo;
        hold = 0; b = 1'b0;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                b = $urandom_range(0, 1) != 0;
                hold = $urandom_range(1, 12);
            end
            hold--;
            ii = $urandom_range(0, 3) == 0;
            oo = $urandom_range(0, 3) == 0;
            cyc(ii, oo, b);
            if (reset) reset = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus.in_inst = 1'b0; bus.out_inst = 1'b0; bus.btn = 1'b0;
        model_reset();
        test_reset();
        test_idle();
        test_input_commit();
        test_bounce();
        test_held();
        test_priority_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/io_stall_ctrl.md
IO_STALL_CTRL -- requirements
Module: io_stall_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 6: consecutive synchronized-high btn samples needed to accept a press; legal range 2..(2**CW-1).
REQ-002 SHALL have parameter CW, default 3: debounce counter width.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_inst  input  1  current instruction is an input (switch-read) instruction.
REQ-006 SHALL have port out_inst  input  1  current instruction is an output (display-write) instruction.
REQ-007 SHALL have port btn  input  1  raw, asynchronous user confirm button.
REQ-008 SHALL have port pc_en  output  1  PC may load its next address this edge.
REQ-009 SHALL have port in_wait  output  1  stalled on an input instruction (drives PC input_flag).
REQ-010 SHALL have port out_wait  output  1  stalled on an output instruction (drives PC output_flag).
REQ-011 SHALL have port in_capture  output  1  one-cycle pulse: write switch value to register file.
REQ-012 SHALL have port out_latch  output  1  one-cycle pulse: latch output value into display register.
REQ-013 SHALL have port stall_count  output  32  total cycles with pc_en low, saturating.

Function
REQ-014 SHALL pass btn through a 2-flop synchronizer; btn_s is btn as sampled two rising edges earlier; only btn_s used internally.
REQ-015 SHALL implement states RUN, WAIT, DEBOUNCE, COMMIT, RELEASE; registered kind bit (IN/OUT); CW-bit counter cnt.
REQ-016 RUN: pc_en = !(in_inst | out_inst); if either high, kind <= IN if in_inst else OUT (in_inst wins when both high), next WAIT.
REQ-017 WAIT: pc_en=0; if btn_s=1, cnt <= 1, next DEBOUNCE; else stay.
REQ-018 DEBOUNCE: pc_en=0; btn_s=0 -> cnt <= 0, next WAIT; btn_s=1 and cnt=DB_CYCLES-1 -> next COMMIT; else cnt <= cnt+1.
REQ-019 COMMIT: exactly one cycle; pc_en=1; in_capture=1 if kind=IN, out_latch=1 if kind=OUT; cnt <= 0; next RELEASE.
REQ-020 RELEASE: pc_en=0; stay while btn_s=1; btn_s=0 -> next RUN (a held button never commits two IO instructions).
REQ-021 in_wait=1 iff kind=IN and state in {WAIT, DEBOUNCE}; out_wait likewise for OUT; never both high.
REQ-022 in_capture and out_latch SHALL be high only in COMMIT, mutually exclusive, never longer than one cycle.
REQ-023 pc_en, in_wait, out_wait, in_capture, out_latch SHALL be combinational from state, kind, in_inst, out_inst only (no btn path).
REQ-024 stall_count SHALL increment by 1 on each edge where pc_en=0 and value < 32'hFFFFFFFF; holds at 32'hFFFFFFFF.
REQ-025 Commit SHALL occur exactly DB_CYCLES edges after the first WAIT edge seeing btn_s=1, given btn_s stays high; any low sample restarts from WAIT.
REQ-026 in_inst/out_inst changes while not in RUN SHALL be ignored.

Reset
REQ-027 reset high SHALL immediately force state=RUN, kind=IN, cnt=0, both sync flops=0, stall_count=0; outputs then follow RUN rules.
REQ-028 reset asserted mid-WAIT/DEBOUNCE/COMMIT SHALL drop any pending commit; no in_capture/out_latch pulse on or after reset.

Verification
REQ-029 Idle run: in_inst=out_inst=0 for 10 cycles -> pc_en=1 throughout, stall_count=0, no pulses.
REQ-030 Input commit: in_inst=1 at cycle 0, btn held high from cycle 2 -> in_wait=1 from cycle 1, btn_s high cycle 4, single in_capture and pc_en=1 pulse 6 cycles later (cycle 10); out_latch never high.
REQ-031 Bounce: out_inst=1, btn high 3 cycles, low 1, then high steady -> no commit until 6 consecutive btn_s highs; exactly one out_latch.
REQ-032 Held button: after commit, btn kept high 20 cycles with next out_inst=1 -> pc_en=0 in RELEASE, no second pulse until btn low then re-pressed.
REQ-033 Priority/reset: in_inst=out_inst=1 -> in_wait=1, out_wait=0; reset pulsed in DEBOUNCE -> RUN, stall_count=0, no pulse.
REQ-034 Saturation: preload/force stall_count=32'hFFFFFFFE, stall 3 cycles -> reads 32'hFFFFFFFF and stays.
